// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush scheduler for the 5-stage RV64I pipeline. It combines three
//   request sources into one set of stall/flush enables for the F/D, D/E, E/M
//   and M/W pipeline registers:
//     - load-use stall requests from the hazard unit
//     - Execute-stage redirects
//     - data-memory wait states
//   After reset release it holds the pipeline flushed for INIT_FLUSH_CYCLES
//   cycles. A watchdog raises Fault if one memory access waits MEM_TIMEOUT
//   consecutive cycles. All outputs are Mealy (combinational from state and
//   inputs).
//
// Parameters
//   INIT_FLUSH_CYCLES  cycles held flushed after reset release (1..15)
//   MEM_TIMEOUT        max consecutive wait cycles per access (2..65535)
//   PERF_W             perf counter width (only with PIPELINE_CTRL_PERF_EN)
//
// Ports
//   clk, rst_n        core clock, synchronous active-low reset
//   LwStall_H         load-use stall request
//   PCSrc_E           branch/jump taken in Execute
//   MemReq_M          Memory-stage instruction accesses data memory
//   MemReady_M        data memory completes the access this cycle
//   Stall_F/D/E/M     hold PC, F/D, D/E, E/M registers
//   Flush_D/E/W       clear F/D, D/E, M/W registers
//   Fault             memory timeout, sticky until reset
//   Busy              controller is not in RUN (or reset is asserted)
//
// Optional feature (macro PIPELINE_CTRL_PERF_EN)
//   PerfLwStall       cycles with a load-use stall applied
//   PerfMemStall      cycles with the memory-wait pattern applied
//   PerfFlush         redirect flush events
//   Counters clear on reset and saturate at all-ones.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int INIT_FLUSH_CYCLES = 4,
  parameter int MEM_TIMEOUT       = 256
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  parameter int PERF_W            = 32
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic LwStall_H,
  input  logic PCSrc_E,
  input  logic MemReq_M,
  input  logic MemReady_M,
  output logic Stall_F,
  output logic Stall_D,
  output logic Stall_E,
  output logic Stall_M,
  output logic Flush_D,
  output logic Flush_E,
  output logic Flush_W,
  output logic Fault,
  output logic Busy
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] PerfLwStall,
  output logic [PERF_W-1:0] PerfMemStall,
  output logic [PERF_W-1:0] PerfFlush
`endif
);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_MEM_WAIT,
    S_FAULT
  } state_t;

  localparam logic [3:0]  ICNT_START = 4'(INIT_FLUSH_CYCLES - 1);
  localparam logic [15:0] WCNT_LAST  = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  icnt_q, icnt_d;
  logic [15:0] wcnt_q, wcnt_d;

  // Which request pattern is applied this cycle (mutually exclusive).
  logic mem_apply;
  logic pc_apply;
  logic lw_apply;
  logic init_apply;
  logic fault_apply;

  // A dropped request while waiting counts as completion, so "still blocked"
  // is the same expression in RUN and MEM_WAIT.
  logic mem_block;
  assign mem_block = MemReq_M & ~MemReady_M;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      icnt_q  <= ICNT_START;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    icnt_d      = icnt_q;
    wcnt_d      = wcnt_q;
    mem_apply   = 1'b0;
    pc_apply    = 1'b0;
    lw_apply    = 1'b0;
    init_apply  = 1'b0;
    fault_apply = 1'b0;

    unique case (state_q)
      S_INIT: begin
        init_apply = 1'b1;
        if (icnt_q == 4'd0) state_d = S_RUN;
        else                icnt_d  = icnt_q - 4'd1;
      end

      S_RUN: begin
        if (mem_block) begin
          mem_apply = 1'b1;
          state_d   = S_MEM_WAIT;
          wcnt_d    = 16'd1;
        end else if (PCSrc_E) begin
          pc_apply = 1'b1;
        end else if (LwStall_H) begin
          lw_apply = 1'b1;
        end
      end

      S_MEM_WAIT: begin
        if (mem_block) begin
          mem_apply = 1'b1;
          wcnt_d    = wcnt_q + 16'd1;
          if (wcnt_q == WCNT_LAST) state_d = S_FAULT;
        end else begin
          // Zero-cycle release: the frozen E/D requests are serviced now.
          if (PCSrc_E)        pc_apply = 1'b1;
          else if (LwStall_H) lw_apply = 1'b1;
          state_d = S_RUN;
          wcnt_d  = '0;
        end
      end

      S_FAULT: begin
        fault_apply = 1'b1;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    // Reset forces the INIT pattern without waiting for the clock edge.
    if (!rst_n) begin
      mem_apply   = 1'b0;
      pc_apply    = 1'b0;
      lw_apply    = 1'b0;
      fault_apply = 1'b0;
      init_apply  = 1'b1;
    end
  end

  // Output decode. Each register is either stalled or flushed, never both:
  // only the F/D..E/M stalls and D/E/W flushes are produced, and no single
  // pattern pairs a stall with a flush on the same register.
  always_comb begin
    Stall_F = init_apply | mem_apply | fault_apply | lw_apply;
    Stall_D = mem_apply | fault_apply | lw_apply;
    Stall_E = mem_apply | fault_apply;
    Stall_M = mem_apply | fault_apply;
    Flush_D = init_apply | pc_apply;
    Flush_E = init_apply | pc_apply | lw_apply;
    Flush_W = init_apply | mem_apply | fault_apply;
    Fault   = fault_apply;
    Busy    = !rst_n || (state_q != S_RUN);
  end

`ifdef PIPELINE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      PerfLwStall  <= '0;
      PerfMemStall <= '0;
      PerfFlush    <= '0;
    end else begin
      if (lw_apply  && !(&PerfLwStall))  PerfLwStall  <= PerfLwStall + 1'b1;
      if (mem_apply && !(&PerfMemStall)) PerfMemStall <= PerfMemStall + 1'b1;
      if (pc_apply  && !(&PerfFlush))    PerfFlush    <= PerfFlush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Self-checking bench for pipeline_ctrl (INIT_FLUSH_CYCLES=4, MEM_TIMEOUT=8).
//   Directed vectors come from a table, the timeout corner is a hand-written
//   sequence, and a randomized phase is compared against a behavioural model.
//   Observed vector bit order: {Stall_F,Stall_D,Stall_E,Stall_M,
//   Flush_D,Flush_E,Flush_W,Fault,Busy}.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int INIT_N = 4;
  localparam int TMO    = 8;

  localparam logic [8:0] P_IDLE  = 9'b0000_000_00;
  localparam logic [8:0] P_INIT  = 9'b1000_111_01;
  localparam logic [8:0] P_LW    = 9'b1100_010_00;
  localparam logic [8:0] P_PC    = 9'b0000_110_00;
  localparam logic [8:0] P_MEM   = 9'b1111_001_00;
  localparam logic [8:0] P_FAULT = 9'b1111_001_11;
  localparam logic [8:0] BUSY    = 9'b0000_000_01;

  logic clk = 1'b0;
  logic rst_n, LwStall_H, PCSrc_E, MemReq_M, MemReady_M;
  logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W;
  logic Fault, Busy;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] PerfLwStall, PerfMemStall, PerfFlush;
`endif

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .INIT_FLUSH_CYCLES(INIT_N),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .LwStall_H(LwStall_H),
    .PCSrc_E(PCSrc_E),
    .MemReq_M(MemReq_M),
    .MemReady_M(MemReady_M),
    .Stall_F(Stall_F),
    .Stall_D(Stall_D),
    .Stall_E(Stall_E),
    .Stall_M(Stall_M),
    .Flush_D(Flush_D),
    .Flush_E(Flush_E),
    .Flush_W(Flush_W),
    .Fault(Fault),
    .Busy(Busy)
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    .PerfLwStall(PerfLwStall),
    .PerfMemStall(PerfMemStall),
    .PerfFlush(PerfFlush)
`endif
  );

  logic [8:0] obs;
  assign obs = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, Fault, Busy};

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: cycles of flush left, whether an access is being waited
  // on, how many consecutive cycles it has waited, and the sticky fault.
  int m_init_left = INIT_N;
  bit m_waiting   = 1'b0;
  int m_waited    = 0;
  bit m_faulted   = 1'b0;
  int m_lw_cnt    = 0;
  int m_mem_cnt   = 0;
  int m_pc_cnt    = 0;

  typedef struct {
    logic       r, lw, pc, req, rdy;
    logic [8:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] model_expect();
    logic [8:0] busy_bit;
    busy_bit = m_waiting ? BUSY : P_IDLE;
    if (!rst_n || m_init_left > 0) return P_INIT;
    if (m_faulted)                 return P_FAULT;
    if (MemReq_M && !MemReady_M)   return P_MEM | busy_bit;
    if (PCSrc_E)                   return P_PC | busy_bit;
    if (LwStall_H)                 return P_LW | busy_bit;
    return busy_bit;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_init_left = INIT_N;
      m_waiting   = 1'b0;
      m_waited    = 0;
      m_faulted   = 1'b0;
      m_lw_cnt    = 0;
      m_mem_cnt   = 0;
      m_pc_cnt    = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end else if (!m_faulted) begin
      if (MemReq_M && !MemReady_M) begin
        m_mem_cnt++;
        m_waited++;
        m_waiting = 1'b1;
        if (m_waited == TMO) m_faulted = 1'b1;
      end else begin
        if (PCSrc_E)        m_pc_cnt++;
        else if (LwStall_H) m_lw_cnt++;
        m_waiting = 1'b0;
        m_waited  = 0;
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well
  // clear of the rising edge that commits the state.
  task automatic drive(input logic r, lw, pc, req, rdy);
    @(negedge clk);
    rst_n      = r;
    LwStall_H  = lw;
    PCSrc_E    = pc;
    MemReq_M   = req;
    MemReady_M = rdy;
    #1;
  endtask

  task automatic cycle_exp(input string name, input logic r, lw, pc, req, rdy,
                           input logic [8:0] exp);
    drive(r, lw, pc, req, rdy);
    check(name, 32'(obs), 32'(exp));
    model_step();
  endtask

  task automatic cycle_model(input string name, input logic r, lw, pc, req, rdy);
    drive(r, lw, pc, req, rdy);
    check(name, 32'(obs), 32'(model_expect()));
    model_step();
  endtask

  function automatic vec_t mk(input logic r, lw, pc, req, rdy,
                              input logic [8:0] exp, input string name);
    vec_t v;
    v.r = r; v.lw = lw; v.pc = pc; v.req = req; v.rdy = rdy;
    v.exp = exp; v.name = name;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; LwStall_H = 1'b0; PCSrc_E = 1'b0; MemReq_M = 1'b0; MemReady_M = 1'b0;

    //                r   lw  pc  req rdy  expected
    tbl.push_back(mk(0,  1,  1,  1,  0,  P_INIT,              "rst0"));
    tbl.push_back(mk(0,  1,  0,  1,  1,  P_INIT,              "rst1"));
    tbl.push_back(mk(0,  0,  1,  0,  0,  P_INIT,              "rst2"));
    tbl.push_back(mk(1,  1,  1,  1,  0,  P_INIT,              "init0"));
    tbl.push_back(mk(1,  1,  0,  1,  0,  P_INIT,              "init1"));
    tbl.push_back(mk(1,  0,  1,  0,  0,  P_INIT,              "init2"));
    tbl.push_back(mk(1,  1,  1,  1,  1,  P_INIT,              "init3"));
    tbl.push_back(mk(1,  0,  0,  0,  0,  P_IDLE,              "run_idle"));
    tbl.push_back(mk(1,  1,  0,  0,  0,  P_LW,                "lw_stall"));
    tbl.push_back(mk(1,  0,  0,  0,  0,  P_IDLE,              "lw_one_cycle"));
    tbl.push_back(mk(1,  1,  1,  0,  0,  P_PC,                "pc_beats_lw"));
    tbl.push_back(mk(1,  0,  0,  0,  0,  P_IDLE,              "after_pc"));
    tbl.push_back(mk(1,  0,  1,  1,  0,  P_MEM,               "mem_wait1"));
    tbl.push_back(mk(1,  0,  1,  1,  0,  P_MEM | BUSY,        "mem_wait2"));
    tbl.push_back(mk(1,  0,  1,  1,  0,  P_MEM | BUSY,        "mem_wait3"));
    tbl.push_back(mk(1,  0,  1,  1,  1,  P_PC | BUSY,         "mem_release_pc"));
    tbl.push_back(mk(1,  0,  0,  0,  0,  P_IDLE,              "back_to_run"));
    tbl.push_back(mk(1,  0,  0,  1,  1,  P_IDLE,              "mem_hit"));
    tbl.push_back(mk(1,  0,  0,  1,  0,  P_MEM,               "mem_wait_b"));
    tbl.push_back(mk(1,  1,  0,  0,  0,  P_LW | BUSY,         "req_drop_release"));
    tbl.push_back(mk(1,  0,  0,  0,  0,  P_IDLE,              "run_idle2"));

    for (int i = 0; i < tbl.size(); i++)
      cycle_exp(tbl[i].name, tbl[i].r, tbl[i].lw, tbl[i].pc, tbl[i].req, tbl[i].rdy, tbl[i].exp);

    // Timeout: 8 wait cycles, then FAULT sticks while inputs toggle.
    for (int i = 1; i <= TMO; i++)
      cycle_exp("timeout_wait", 1, 0, 0, 1, 0, (i == 1) ? P_MEM : (P_MEM | BUSY));
    for (int i = 0; i < 5; i++)
      cycle_exp("fault_sticky", 1, 1'(i), 1'(i + 1), 1'(i >> 1), 1'(i), P_FAULT);
    cycle_exp("fault_reset", 0, 1, 1, 1, 0, P_INIT);
    for (int i = 0; i < INIT_N; i++)
      cycle_exp("fault_reinit", 1, 0, 1, 1, 0, P_INIT);
    cycle_exp("reinit_run", 1, 0, 0, 0, 0, P_IDLE);

    // Randomized phase with a varying memory-ready bias so that short
    // waits, long waits and timeouts all occur.
    begin
      int bias;
      bias = 60;
      for (int n = 0; n < 3000; n++) begin
        if (n % 200 == 0) begin
          case ($urandom_range(0, 2))
            0: bias = 15;
            1: bias = 60;
            default: bias = 90;
          endcase
        end
        cycle_model("random",
                    ($urandom_range(0, 59) != 0),
                    1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 99) < bias));
      end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    // Counters from a fresh reset: 5 load-use stalls, 2 redirects,
    // one 3-cycle memory wait.
    cycle_exp("perf_reset", 0, 0, 0, 0, 0, P_INIT);
    for (int i = 0; i < INIT_N; i++) cycle_exp("perf_init", 1, 0, 0, 0, 0, P_INIT);
    for (int i = 0; i < 5; i++) begin
      cycle_exp("perf_lw", 1, 1, 0, 0, 0, P_LW);
      cycle_exp("perf_gap", 1, 0, 0, 0, 0, P_IDLE);
    end
    cycle_exp("perf_pc", 1, 0, 1, 0, 0, P_PC);
    cycle_exp("perf_pc", 1, 0, 1, 0, 0, P_PC);
    cycle_exp("perf_mem", 1, 0, 0, 1, 0, P_MEM);
    cycle_exp("perf_mem", 1, 0, 0, 1, 0, P_MEM | BUSY);
    cycle_exp("perf_mem", 1, 0, 0, 1, 0, P_MEM | BUSY);
    cycle_exp("perf_rel", 1, 0, 0, 1, 1, BUSY);
    @(negedge clk);
    check("perf_lw_cnt",  PerfLwStall,  32'd5);
    check("perf_pc_cnt",  PerfFlush,    32'd2);
    check("perf_mem_cnt", PerfMemStall, 32'd3);
    check("perf_lw_model",  PerfLwStall,  32'(m_lw_cnt));
    check("perf_pc_model",  PerfFlush,    32'(m_pc_cnt));
    check("perf_mem_model", PerfMemStall, 32'(m_mem_cnt));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "time limit");
  end

endmodule
